// File: rtl/special_reg_bank_if.sv
// special_reg_bank_if: user read/write ports plus PC/SP/LR/flag control and status of the special register bank.
interface special_reg_bank_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
);
  logic              usr_wr_en;
  logic [ADDR_W-1:0] usr_wr_addr;
  logic [DATA_W-1:0] usr_wr_data;
  logic [ADDR_W-1:0] usr_rd_addr_a;
  logic [DATA_W-1:0] usr_rd_data_a;
  logic [ADDR_W-1:0] usr_rd_addr_b;
  logic [DATA_W-1:0] usr_rd_data_b;
  logic              pc_adv;
  logic              br_valid;
  logic [DATA_W-1:0] br_target;
  logic              br_link;
  logic              push;
  logic              pop;
  logic              flag_wr;
  logic [3:0]        flag_in;
  logic              fault_clr;
  logic [DATA_W-1:0] re_pc;
  logic [DATA_W-1:0] re_sp;
  logic [DATA_W-1:0] re_lr;
  logic [DATA_W-1:0] re_cpsr;
  logic              stack_fault;
  modport master (
    output usr_wr_en, usr_wr_addr, usr_wr_data, usr_rd_addr_a, usr_rd_addr_b,
           pc_adv, br_valid, br_target, br_link, push, pop, flag_wr, flag_in, fault_clr,
    input  usr_rd_data_a, usr_rd_data_b, re_pc, re_sp, re_lr, re_cpsr, stack_fault
  );
  modport slave (
    input  usr_wr_en, usr_wr_addr, usr_wr_data, usr_rd_addr_a, usr_rd_addr_b,
           pc_adv, br_valid, br_target, br_link, push, pop, flag_wr, flag_in, fault_clr,
    output usr_rd_data_a, usr_rd_data_b, re_pc, re_sp, re_lr, re_cpsr, stack_fault
  );
endinterface

// File: rtl/special_reg_bank.sv
// special_reg_bank: ZR/spare/SP/LR/PC/CPSR register file owning PC, SP, LR and NZCV update logic.
// Define SPECIAL_REG_BYPASS_EN to forward same-cycle user writes onto the read ports.
module special_reg_bank #(
  parameter int                 DATA_W      = 32,
  parameter int                 NUM_REGS    = 8,
  parameter int                 ADDR_W      = 3,
  parameter int                 PC_STEP     = 4,
  parameter logic [DATA_W-1:0]  SP_RESET    = 'h0000_1000,
  parameter logic [DATA_W-1:0]  STACK_LIMIT = 'h0000_0800
) (
  input  logic                clk,
  input  logic                reset,
  special_reg_bank_if.slave   bus
);
  localparam logic [DATA_W:0] STEP_B = (DATA_W+1)'(DATA_W/8);
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] nxt  [NUM_REGS];
  logic [DATA_W-1:0] pc, sp, link;
  logic push_only, pop_only, push_fault, pop_fault, byp_a, byp_b;
  assign pc   = regs[6];
  assign sp   = regs[4];
  assign link = pc + DATA_W'(PC_STEP);
  assign push_only = bus.push & ~bus.pop;
  assign pop_only  = bus.pop & ~bus.push;
  // Bounds compared one bit wider so a user-written SP near 0 or 2^DATA_W cannot wrap the check.
  assign push_fault = push_only && ({1'b0, sp} < {1'b0, STACK_LIMIT} + STEP_B);
  assign pop_fault  = pop_only && ({1'b0, sp} + STEP_B > {1'b0, SP_RESET});
  always_comb begin
    nxt = regs;
    if (bus.usr_wr_en) nxt[bus.usr_wr_addr] = bus.usr_wr_data;
    nxt[0] = '0;
    if (bus.br_valid) nxt[6] = bus.br_target;
    else if (bus.pc_adv && !(bus.usr_wr_en && bus.usr_wr_addr == ADDR_W'(6))) nxt[6] = link;
    if (bus.br_valid && bus.br_link) nxt[5] = link;
    if (bus.push || bus.pop) nxt[4] = (push_only && !push_fault) ? sp - DATA_W'(DATA_W/8) :
                                      (pop_only && !pop_fault) ? sp + DATA_W'(DATA_W/8) : sp;
    if (bus.flag_wr) nxt[7][DATA_W-1 -: 4] = bus.flag_in;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= (i == 4) ? SP_RESET : '0;
      bus.stack_fault <= 1'b0;
    end else begin
      regs <= nxt;
      bus.stack_fault <= push_fault | pop_fault | (bus.stack_fault & ~bus.fault_clr);
    end
  end
`ifdef SPECIAL_REG_BYPASS_EN
  assign byp_a = bus.usr_wr_en && bus.usr_wr_addr == bus.usr_rd_addr_a;
  assign byp_b = bus.usr_wr_en && bus.usr_wr_addr == bus.usr_rd_addr_b;
`else
  assign byp_a = 1'b0;
  assign byp_b = 1'b0;
`endif
  assign bus.usr_rd_data_a = (bus.usr_rd_addr_a == '0) ? '0 : byp_a ? bus.usr_wr_data : regs[bus.usr_rd_addr_a];
  assign bus.usr_rd_data_b = (bus.usr_rd_addr_b == '0) ? '0 : byp_b ? bus.usr_wr_data : regs[bus.usr_rd_addr_b];
  assign bus.re_pc   = regs[6];
  assign bus.re_sp   = regs[4];
  assign bus.re_lr   = regs[5];
  assign bus.re_cpsr = regs[7];
endmodule

// File: tb/tb_special_reg_bank.sv
// tb_special_reg_bank: directed checks of reset, PC/LR, stack bounds, flags, ZR, bypass and async reset.
module tb_special_reg_bank;
  logic clk = 1'b0;
  logic reset;
  int passed = 0;
  int total = 0;
  special_reg_bank_if #(.DATA_W(32), .ADDR_W(3)) bus ();
  special_reg_bank dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.usr_wr_en = 0; bus.usr_wr_addr = 0; bus.usr_wr_data = 0;
    bus.pc_adv = 0; bus.br_valid = 0; bus.br_target = 0; bus.br_link = 0;
    bus.push = 0; bus.pop = 0; bus.flag_wr = 0; bus.flag_in = 0; bus.fault_clr = 0;
  endtask
  initial begin
    idle();
    bus.usr_rd_addr_a = 0; bus.usr_rd_addr_b = 0;
    reset = 1;
    #2;
    check("rst_sp", bus.re_sp, 32'h1000);
    check("rst_pc", bus.re_pc, 32'h0);
    check("rst_lr", bus.re_lr, 32'h0);
    check("rst_cpsr", bus.re_cpsr, 32'h0);
    check("rst_fault", 32'(bus.stack_fault), 32'h0);
    #1 reset = 0;
    tick();
    bus.pc_adv = 1;
    repeat (3) tick();
    check("pc_adv3", bus.re_pc, 32'hC);
    bus.br_valid = 1; bus.br_link = 1; bus.br_target = 32'h200;
    tick();
    check("br_pc", bus.re_pc, 32'h200);
    check("br_lr", bus.re_lr, 32'h10);
    idle();
    bus.usr_wr_en = 1; bus.usr_wr_addr = 6; bus.usr_wr_data = 32'hFFFF_FFFC; bus.pc_adv = 1;
    tick();
    check("usr_pc_over_adv", bus.re_pc, 32'hFFFF_FFFC);
    idle();
    bus.pc_adv = 1;
    tick();
    check("pc_wrap", bus.re_pc, 32'h0);
    idle();
    bus.push = 1;
    repeat (512) tick();
    check("push512_sp", bus.re_sp, 32'h800);
    check("push512_fault", 32'(bus.stack_fault), 32'h0);
    tick();
    check("push513_sp", bus.re_sp, 32'h800);
    check("push513_fault", 32'(bus.stack_fault), 32'h1);
    idle();
    bus.fault_clr = 1;
    tick();
    check("fault_clr", 32'(bus.stack_fault), 32'h0);
    idle();
    bus.pop = 1; bus.usr_wr_en = 1; bus.usr_wr_addr = 4; bus.usr_wr_data = 32'h1234;
    tick();
    check("pop_over_usr", bus.re_sp, 32'h804);
    idle();
    bus.push = 1; bus.pop = 1;
    tick();
    check("pushpop_sp", bus.re_sp, 32'h804);
    check("pushpop_fault", 32'(bus.stack_fault), 32'h0);
    idle();
    bus.usr_wr_en = 1; bus.usr_wr_addr = 4; bus.usr_wr_data = 32'h1000;
    tick();
    check("usr_sp", bus.re_sp, 32'h1000);
    idle();
    bus.pop = 1; bus.fault_clr = 1;
    tick();
    check("pop_top_sp", bus.re_sp, 32'h1000);
    check("pop_top_fault_set_wins", 32'(bus.stack_fault), 32'h1);
    idle();
    bus.fault_clr = 1;
    tick();
    idle();
    bus.usr_wr_en = 1; bus.usr_wr_addr = 7; bus.usr_wr_data = 32'hFFFF_FFFF;
    bus.flag_wr = 1; bus.flag_in = 4'b0101;
    tick();
    check("cpsr_merge", bus.re_cpsr, 32'h5FFF_FFFF);
    idle();
    bus.flag_wr = 1; bus.flag_in = 4'b1010;
    tick();
    check("cpsr_flags", bus.re_cpsr, 32'hAFFF_FFFF);
    idle();
    bus.usr_wr_en = 1; bus.usr_wr_addr = 0; bus.usr_wr_data = 32'hDEAD;
    tick();
    idle();
    check("zr_a", bus.usr_rd_data_a, 32'h0);
    check("zr_b", bus.usr_rd_data_b, 32'h0);
    bus.usr_rd_addr_a = 2; bus.usr_rd_addr_b = 3;
    bus.usr_wr_en = 1; bus.usr_wr_addr = 2; bus.usr_wr_data = 32'hBEEF;
    #1;
`ifdef SPECIAL_REG_BYPASS_EN
    check("bypass_a", bus.usr_rd_data_a, 32'hBEEF);
`else
    check("bypass_a", bus.usr_rd_data_a, 32'h0);
`endif
    check("bypass_b_other", bus.usr_rd_data_b, 32'h0);
    tick();
    idle();
    check("rd_a_next", bus.usr_rd_data_a, 32'hBEEF);
    bus.usr_rd_addr_b = 2;
    #1 check("rd_b_next", bus.usr_rd_data_b, 32'hBEEF);
    bus.usr_rd_addr_a = 3;
    bus.push = 1; bus.usr_wr_en = 1; bus.usr_wr_addr = 3; bus.usr_wr_data = 32'h55;
    tick();
    check("pre_rst_sp", bus.re_sp, 32'hFFC);
    check("pre_rst_r3", bus.usr_rd_data_a, 32'h55);
    bus.usr_wr_data = 32'h77;
    #3 reset = 1;
    #1;
    check("arst_sp", bus.re_sp, 32'h1000);
    check("arst_r3", bus.usr_rd_data_a, 32'h0);
    check("arst_pc", bus.re_pc, 32'h0);
    check("arst_cpsr", bus.re_cpsr, 32'h0);
    tick();
    check("arst_hold_sp", bus.re_sp, 32'h1000);
    check("arst_hold_r3", bus.usr_rd_data_a, 32'h0);
    idle();
    reset = 0;
    tick();
    check("post_rst_sp", bus.re_sp, 32'h1000);
    check("post_rst_r2", bus.usr_rd_data_b, 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/special_reg_bank.md
Name: special_reg_bank

Overview:
- Parametrised successor to the SCC special-register file: holds ZR, general spare regs, SP, LR, PC and CPSR for the single-cycle core.
- Owns the PC, SP and flag update logic that was previously done outside the register file:
  - PC advance and branch load.
  - SP push/pop with stack-bound checking.
  - LR link on branch-and-link.
  - NZCV flag merge.
- Provides two combinational user read ports and one clocked user write port.

Parameters:
DATA_W, 32, register width in bits
NUM_REGS, 8, register count; power of 2, >= 8
ADDR_W, 3, log2(NUM_REGS)
PC_STEP, 4, PC increment per retired instruction
SP_RESET, 'h0000_1000, SP value after reset; top of stack, empty
STACK_LIMIT, 'h0000_0800, lowest legal SP value

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
usr_wr_en  in  1  user write strobe
usr_wr_addr  in  ADDR_W  user write index
usr_wr_data  in  DATA_W  user write data
usr_rd_addr_a  in  ADDR_W  read port A index
usr_rd_data_a  out  DATA_W  read port A data
usr_rd_addr_b  in  ADDR_W  read port B index
usr_rd_data_b  out  DATA_W  read port B data
pc_adv  in  1  PC += PC_STEP
br_valid  in  1  load PC from br_target
br_target  in  DATA_W  branch destination
br_link  in  1  with br_valid: LR <= PC + PC_STEP
push  in  1  SP -= DATA_W/8
pop  in  1  SP += DATA_W/8
flag_wr  in  1  write NZCV
flag_in  in  4  {N,Z,C,V}
fault_clr  in  1  clear stack_fault
re_pc  out  DATA_W  current PC (reg 6)
re_sp  out  DATA_W  current SP (reg 4)
re_lr  out  DATA_W  current LR (reg 5)
re_cpsr  out  DATA_W  current CPSR (reg 7)
stack_fault  out  1  sticky stack over/underflow flag

Behaviour:

Reset:
- Asynchronous reset forces all registers to 0, except SP = SP_RESET.
- stack_fault = 0.
- All outputs reflect these values immediately, with no clock needed.

Fixed register map: 0 = ZR, 4 = SP, 5 = LR, 6 = PC, 7 = CPSR. Indices 1-3 and 8+ are plain storage.

Zero register:
- Reads of index 0 always return 0.
- Writes to index 0 are discarded.

Reads:
- Combinational from current state, with no bypass (see optional feature).
- Latency 0.

Writes: all register updates occur on the rising edge of clk. One update per register per cycle, by this priority:
- PC: br_valid > usr write to 6 > pc_adv > hold. pc_adv is ignored when br_valid is high.
- LR: (br_valid & br_link) > usr write to 5 > hold. Link value is the pre-edge PC + PC_STEP, mod 2^DATA_W.
- SP: push/pop > usr write to 4 > hold.
  - push & pop both high: SP unchanged, no fault.
  - push when SP - DATA_W/8 < STACK_LIMIT (unsigned): SP held, stack_fault <= 1.
  - pop when SP + DATA_W/8 > SP_RESET: SP held, stack_fault <= 1.
  - A legal push or pop still suppresses a same-cycle usr write to SP.
- CPSR: usr write to 7 applies to the full word first; then flag_wr overrides bits [31:28] with flag_in. Other bits are unaffected by flag_wr.
- Other indices: usr write only.

stack_fault:
- Sticky; cleared only by fault_clr or reset.
- Same-cycle set and fault_clr: set wins.

Arithmetic: all PC and LR arithmetic wraps mod 2^DATA_W. SP arithmetic never wraps because of the bound checks.

Reset mid-operation: reset asserted during any strobe aborts it. Registers take their reset values; no partial update survives.

Out-of-range addresses: not possible (NUM_REGS = 2^ADDR_W).

Optional Feature:
- Macro SPECIAL_REG_BYPASS_EN.
- Defined: each read port returns usr_wr_data when usr_wr_en is high and usr_wr_addr equals its read address (non-zero), i.e. write-through forwarding.
  - Bypass reflects the user write only. It does not reflect PC, SP, LR or flag side-effects, nor their priority overrides.
- Undefined: reads return stored state only; a write is visible from the cycle after the edge.

Test Plan:
- Reset with SP_RESET default -> re_sp = 'h1000, re_pc = 0, re_cpsr = 0, stack_fault = 0 without any clock edge.
- pc_adv for 3 cycles, then br_valid = 1 + br_link = 1 + br_target = 'h200 + pc_adv = 1 -> PC = 'h200, LR = 'h10.
- 512 pushes from 'h1000 -> SP = 'h800, no fault; 513th push -> SP stays 'h800, stack_fault = 1; fault_clr -> 0. Also a pop at SP = 'h1000 -> SP held, fault = 1.
- usr write 'hFFFF_FFFF to CPSR with flag_wr = 1, flag_in = 4'b0101 same cycle -> CPSR = 'h5FFF_FFFF.
- usr write 'hDEAD to reg 0 -> read ports at index 0 return 0. Write 'hBEEF to reg 2 with read A = 2 same cycle -> 'hBEEF if SPECIAL_REG_BYPASS_EN is defined, old value 0 otherwise; 'hBEEF the next cycle in both builds.
- Assert reset asynchronously mid-cycle while push and usr write to reg 3 are active -> SP = 'h1000, reg 3 = 0 immediately, and they stay there after the next edge.
